// File: rtl/enc_pkg.sv
// ---------------------------------------------------------------------------
// enc_pkg
// Shared definitions for the priority-encoder drain block:
//   - state_t / ST_IDLE / ST_DRAIN : FSM state encoding
//   - PRIO_MSB_FIRST / PRIO_LSB_FIRST : values for the MSB_FIRST parameter
//   - clog2() : elaboration-time ceil(log2(value)), used to size index ports
// ---------------------------------------------------------------------------
package enc_pkg;

   typedef logic [0:0] state_t;

   localparam state_t ST_IDLE  = 1'b0;
   localparam state_t ST_DRAIN = 1'b1;

   localparam int PRIO_MSB_FIRST = 1;
   localparam int PRIO_LSB_FIRST = 0;

   // Smallest r with 2**r >= value. Bounded loop so it stays a legal
   // constant function for every tool.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage : enc_pkg

// File: rtl/prio_pick.sv
// ---------------------------------------------------------------------------
// prio_pick
// Purely combinational priority selector. Finds the highest (MSB_FIRST = 1)
// or lowest (MSB_FIRST = 0) set bit of vec.
//
// Parameters
//   N          number of request lines (2..64)
//   MSB_FIRST  1: highest set index wins, 0: lowest set index wins
//   W          index width, derived as clog2(N)
//
// Ports
//   vec     in   N  request vector
//   idx     out  W  binary index of the winning bit (0 when vec = 0)
//   onehot  out  N  one-hot mask of the winning bit (0 when vec = 0)
//   single  out  1  vec has exactly one bit set
// ---------------------------------------------------------------------------
module prio_pick
   import enc_pkg::*;
#(
   parameter  int N         = 8,
   parameter  int MSB_FIRST = PRIO_MSB_FIRST,
   localparam int W         = clog2(N)
) (
   input  logic [N-1:0] vec,
   output logic [W-1:0] idx,
   output logic [N-1:0] onehot,
   output logic         single
);

   logic found;

   always_comb begin
      idx    = '0;
      onehot = '0;
      found  = 1'b0;
      if (MSB_FIRST != 0) begin
         for (int i = N - 1; i >= 0; i--) begin
            if (vec[i] && !found) begin
               idx       = W'(i);
               onehot[i] = 1'b1;
               found     = 1'b1;
            end
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (vec[i] && !found) begin
               idx       = W'(i);
               onehot[i] = 1'b1;
               found     = 1'b1;
            end
         end
      end
   end

   // Clearing the lowest set bit leaves zero exactly when one bit was set.
   assign single = (vec != '0) && ((vec & (vec - 1'b1)) == '0);

endmodule : prio_pick

// File: rtl/prio_enc_drain.sv
// ---------------------------------------------------------------------------
// prio_enc_drain
// Accepts an N-bit request vector and drains it one set-bit index per beat,
// in priority order (highest index first when MSB_FIRST = 1, lowest first
// otherwise). An all-zero vector yields a single beat flagged out_zero.
// A new vector may be accepted on the final beat of the current one, so
// consecutive vectors stream with no bubble.
//
// Parameters
//   N          number of request lines (2..64)
//   MSB_FIRST  1: highest set index first, 0: lowest set index first
//   W          index width, derived as clog2(N)
//
// Ports
//   clk        in   1  clock, rising edge
//   rst_n      in   1  synchronous active-low reset
//   in_valid   in   1  in_vec offered
//   in_ready   out  1  in_vec accepted this cycle
//   in_vec     in   N  request vector
//   out_valid  out  1  beat outputs valid
//   out_ready  in   1  downstream consumes current beat
//   out_idx    out  W  selected index
//   out_last   out  1  final beat of the latched vector
//   out_zero   out  1  latched vector was all-zero
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | nothing pending; in_ready = 1, out_valid = 0
// ST_DRAIN | pend holds remaining bits; one beat per out_ready cycle
// ---------------------------------------------------------------------------
module prio_enc_drain
   import enc_pkg::*;
#(
   parameter  int N         = 8,
   parameter  int MSB_FIRST = PRIO_MSB_FIRST,
   localparam int W         = clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_vec,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_idx,
   output logic         out_last,
   output logic         out_zero
);

   state_t       state;
   logic [N-1:0] pend;

   logic [W-1:0] pick_idx;
   logic [N-1:0] pick_onehot;
   logic         pick_single;

   logic         in_xfer;
   logic         out_xfer;
   logic         pend_zero;
   logic         in_drain;

   prio_pick #(
      .N         (N),
      .MSB_FIRST (MSB_FIRST)
   ) u_pick (
      .vec    (pend),
      .idx    (pick_idx),
      .onehot (pick_onehot),
      .single (pick_single)
   );

   assign in_drain  = (state == ST_DRAIN);
   assign pend_zero = (pend == '0);

   // pend is 0 in IDLE, so the index decode is already 0 there; last/zero
   // must be qualified by the state so they read 0 out of reset.
   assign out_valid = in_drain;
   assign out_idx   = pick_idx;
   assign out_last  = in_drain && (pick_single || pend_zero);
   assign out_zero  = in_drain && pend_zero;

   // In DRAIN, accepting is only safe when the current beat empties pend.
   assign in_ready  = in_drain ? (out_ready && out_last) : 1'b1;

   assign in_xfer   = in_valid && in_ready;
   assign out_xfer  = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         pend  <= '0;
      end else begin
         if (in_xfer) begin
            // Covers both the IDLE load and the back-to-back reload.
            state <= ST_DRAIN;
            pend  <= in_vec;
         end else if (out_xfer) begin
            pend <= pend & ~pick_onehot;
            if (out_last) state <= ST_IDLE;
         end
      end
   end

endmodule : prio_enc_drain

// File: tb/tb_prio_enc_drain.sv
module tb_prio_enc_drain;

   typedef struct {
      int idx;
      bit last;
      bit zero;
   } beat_t;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] in_vec;
   logic       out_ready;

   logic       rdy_m, val_m, last_m, zero_m;
   logic [2:0] idx_m;
   logic       rdy_l, val_l, last_l, zero_l;
   logic [2:0] idx_l;

   int n_cmp = 0;
   int n_err = 0;

   beat_t q_m[$];
   beat_t q_l[$];
   int    cap_m[$];
   int    cap_l[$];
   int    cap_last_m[$];
   int    exp_seq[$];
   bit    chk_en = 1'b0;

   prio_enc_drain #(.N(8), .MSB_FIRST(1)) dut_m (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (rdy_m),
      .in_vec    (in_vec),
      .out_valid (val_m),
      .out_ready (out_ready),
      .out_idx   (idx_m),
      .out_last  (last_m),
      .out_zero  (zero_m)
   );

   prio_enc_drain #(.N(8), .MSB_FIRST(0)) dut_l (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (rdy_l),
      .in_vec    (in_vec),
      .out_valid (val_l),
      .out_ready (out_ready),
      .out_idx   (idx_l),
      .out_last  (last_l),
      .out_zero  (zero_l)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Expected beat list for a vector: every set index once, in priority
   // order, last flag on the final one; a zero vector is one zero beat.
   task automatic load_model(input logic [7:0] v);
      if (v == 8'h00) begin
         q_m.push_back('{0, 1'b1, 1'b1});
         q_l.push_back('{0, 1'b1, 1'b1});
      end else begin
         for (int i = 7; i >= 0; i--)
            if (v[i]) q_m.push_back('{i, 1'b0, 1'b0});
         for (int i = 0; i < 8; i++)
            if (v[i]) q_l.push_back('{i, 1'b0, 1'b0});
         q_m[q_m.size()-1].last = 1'b1;
         q_l[q_l.size()-1].last = 1'b1;
      end
   endtask

   function automatic bit model_ready(input bit msb);
      if (msb) return (q_m.size() == 0) || (out_ready && q_m[0].last);
      else     return (q_l.size() == 0) || (out_ready && q_l[0].last);
   endfunction

   // Model advance: beat pops first, then a same-edge accept appends.
   always @(posedge clk) begin
      bit acc;
      chk_en <= 1'b1;
      if (!rst_n) begin
         q_m.delete();
         q_l.delete();
      end else begin
         acc = in_valid && model_ready(1'b1);
         if (q_m.size() != 0 && out_ready) void'(q_m.pop_front());
         if (q_l.size() != 0 && out_ready) void'(q_l.pop_front());
         if (acc) load_model(in_vec);
      end
   end

   // Compare process, mid-cycle.
   always @(negedge clk) begin
      if (chk_en) begin
         check("m_valid", val_m, q_m.size() != 0);
         check("l_valid", val_l, q_l.size() != 0);
         check("m_ready", rdy_m, model_ready(1'b1));
         check("l_ready", rdy_l, model_ready(1'b0));
         if (q_m.size() != 0 && val_m) begin
            check("m_idx",  idx_m,  q_m[0].idx);
            check("m_last", last_m, q_m[0].last);
            check("m_zero", zero_m, q_m[0].zero);
         end
         if (q_l.size() != 0 && val_l) begin
            check("l_idx",  idx_l,  q_l[0].idx);
            check("l_last", last_l, q_l[0].last);
            check("l_zero", zero_l, q_l[0].zero);
         end
         if (val_m && out_ready) begin
            cap_m.push_back(int'(idx_m));
            cap_last_m.push_back(int'(last_m));
         end
         if (val_l && out_ready) cap_l.push_back(int'(idx_l));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_cap();
      cap_m.delete();
      cap_l.delete();
      cap_last_m.delete();
   endtask

   // which: 0 = msb indices, 1 = lsb indices, 2 = msb last flags
   task automatic check_cap(input string name, input int which);
      int got;
      int sz;
      sz = (which == 0) ? cap_m.size() : (which == 1) ? cap_l.size() : cap_last_m.size();
      check({name, "_len"}, sz, exp_seq.size());
      for (int i = 0; i < exp_seq.size(); i++) begin
         if (i < sz)
            got = (which == 0) ? cap_m[i] : (which == 1) ? cap_l[i] : cap_last_m[i];
         else
            got = -1;
         check(name, got, exp_seq[i]);
      end
   endtask

   task automatic send(input logic [7:0] v);
      in_valid = 1'b1;
      in_vec   = v;
      step();
      in_valid = 1'b0;
   endtask

   task automatic drain(input int max_cycles);
      int n;
      n = 0;
      while (val_m && n < max_cycles) begin
         step();
         n++;
      end
      if (val_m) check("drain_timeout", 1, 0);
   endtask

   initial begin
      int cycles;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_vec    = 8'h00;
      out_ready = 1'b0;
      step();
      step();
      check("rst_valid", val_m, 0);
      check("rst_ready", rdy_m, 1);
      check("rst_idx",   idx_m, 0);
      check("rst_last",  last_m, 0);
      check("rst_zero",  zero_m, 0);
      rst_n = 1'b1;

      // Single-hot, accepted in the first cycle out of reset.
      out_ready = 1'b1;
      clear_cap();
      send(8'b0010_0000);
      check("single_valid", val_m, 1);
      check("single_idx",   idx_m, 5);
      check("single_last",  last_m, 1);
      check("single_zero",  zero_m, 0);
      step();
      check("single_idle",  val_m, 0);

      // Multi-hit, both priority orders.
      clear_cap();
      send(8'b1010_0110);
      cycles = 0;
      while (val_m && cycles < 20) begin
         step();
         cycles++;
      end
      check("multi_cycles", cycles, 4);
      exp_seq = '{7, 5, 2, 1};
      check_cap("multi_msb", 0);
      exp_seq = '{1, 2, 5, 7};
      check_cap("multi_lsb", 1);
      exp_seq = '{0, 0, 0, 1};
      check_cap("multi_last", 2);

      // Zero vector.
      send(8'h00);
      check("zero_idx",  idx_m, 0);
      check("zero_last", last_m, 1);
      check("zero_zero", zero_m, 1);
      step();
      check("zero_idle", val_m, 0);

      // Backpressure; in_vec wiggles while not offered must be ignored.
      out_ready = 1'b0;
      clear_cap();
      send(8'hC0);
      for (int i = 0; i < 3; i++) begin
         check("bp_hold_idx", idx_m, 7);
         check("bp_hold_val", val_m, 1);
         in_vec = 8'($urandom_range(0, 255));
         step();
      end
      out_ready = 1'b1;
      drain(10);
      exp_seq = '{7, 6};
      check_cap("bp_msb", 0);

      // Back-to-back, no bubble.
      clear_cap();
      send(8'h01);
      check("b2b_first_idx", idx_m, 0);
      check("b2b_ready",     rdy_m, 1);
      in_valid = 1'b1;
      in_vec   = 8'h80;
      step();
      in_valid = 1'b0;
      check("b2b_second_val", val_m, 1);
      check("b2b_second_idx", idx_m, 7);
      check("b2b_second_last", last_m, 1);
      step();
      check("b2b_idle", val_m, 0);
      exp_seq = '{0, 7};
      check_cap("b2b_msb", 0);

      // Reset mid-drain after two beats.
      send(8'hFF);
      step();
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("mid_rst_valid", val_m, 0);
      check("mid_rst_ready", rdy_m, 1);
      clear_cap();
      send(8'h08);
      drain(10);
      exp_seq = '{3};
      check_cap("post_rst_msb", 0);
      check_cap("post_rst_lsb", 1);

      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_prio_enc_drain

// File: doc/prio_enc_drain.md
PRIO_ENC_DRAIN -- requirements
Module: prio_enc_drain

Interface
REQ-001 Parameter N, default 8: number of input request lines; legal range 2..64.
REQ-002 Parameter MSB_FIRST, default 1: 1 means the highest set index is emitted first; 0 means the lowest set index is emitted first.
REQ-003 Derived constant W = ceil(log2(N)): width of the index output; not user-overridable.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  in_vec is offered this cycle.
REQ-007 in_ready  output  1  block accepts in_vec this cycle.
REQ-008 in_vec  input  N  request bit vector; bit i set means line i is active.
REQ-009 out_valid  output  1  out_idx, out_last and out_zero are valid.
REQ-010 out_ready  input  1  downstream consumes the current beat.
REQ-011 out_idx  output  W  binary index of the selected set bit.
REQ-012 out_last  output  1  current beat is the final beat for the latched vector.
REQ-013 out_zero  output  1  latched vector was all-zero; out_idx = 0 on that beat.

Function
REQ-014 The block SHALL implement a two-state FSM: IDLE and DRAIN.
REQ-015 The block SHALL transfer an input only on in_valid && in_ready, and a beat only on out_valid && out_ready.
REQ-016 IDLE: in_ready = 1 and out_valid = 0; on input transfer, the block SHALL latch in_vec into the pending register pend and move to DRAIN.
REQ-017 DRAIN: out_valid = 1. out_idx SHALL be the highest set index of pend when MSB_FIRST = 1, else the lowest set index.
REQ-018 out_last SHALL be 1 when pend has exactly one bit set, or when pend = 0.
REQ-019 out_zero SHALL be 1 only when pend = 0 in DRAIN; such a vector produces exactly one beat with out_idx = 0, out_last = 1, out_zero = 1.
REQ-020 On a beat transfer with out_last = 0, the block SHALL clear the emitted bit in pend and remain in DRAIN.
REQ-021 On a beat transfer with out_last = 1, the block SHALL return to IDLE unless a new input is accepted in the same cycle.
REQ-022 Back-to-back: in DRAIN, in_ready SHALL equal out_ready && out_last. A simultaneous input transfer loads the new in_vec into pend and the block stays in DRAIN, with no bubble cycle.
REQ-023 Latency: a vector accepted at edge T SHALL present its first beat at cycle T+1; sustained throughput is one index per cycle while out_ready = 1.
REQ-024 A vector with k set bits (k >= 1) SHALL produce exactly k beats, each index once, in strict priority order.
REQ-025 When out_ready = 0 in DRAIN, out_idx, out_last and out_zero SHALL hold stable.
REQ-026 in_vec SHALL be sampled only on an input transfer; changes at other times have no effect.
REQ-027 out_idx, out_last and out_zero SHALL be combinational decodes of pend; out_valid SHALL decode directly from the state register.

Reset
REQ-028 While rst_n = 0 at a rising clk edge, state SHALL go to IDLE and pend SHALL go to 0.
REQ-029 Reset values: out_valid = 0, in_ready = 1, out_idx = 0, out_last = 0, out_zero = 0.
REQ-030 Reset asserted mid-DRAIN SHALL discard all remaining beats; no partial vector survives reset.
REQ-031 The first input transfer is possible in the first cycle after rst_n is sampled high.

Structure
REQ-032 Shared package enc_pkg SHALL hold: the FSM state type (IDLE, DRAIN), the clog2 helper function, and the MSB_FIRST/LSB_FIRST constants.
REQ-033 A single combinational sub-module prio_pick (parameters N, MSB_FIRST; input vec; outputs idx, onehot, single) SHALL perform selection.
REQ-034 prio_enc_drain SHALL instantiate prio_pick once.
REQ-035 For N = 8, MSB_FIRST = 1 and a single-hot input, prio_pick idx SHALL match the 8-to-3 encoder truth table.

Verification (N = 8 unless stated)
REQ-036 Single-hot: in_vec = 8'b0010_0000, out_ready = 1 -> one beat at T+1: idx = 5, last = 1, zero = 0; IDLE at T+2.
REQ-037 Multi-hit, MSB_FIRST = 1: in_vec = 8'b1010_0110 -> beats idx 7, 5, 2, 1 on consecutive cycles; last = 1 only on idx 1. With MSB_FIRST = 0 the order is 1, 2, 5, 7.
REQ-038 Zero vector: in_vec = 0 -> one beat: idx = 0, last = 1, zero = 1.
REQ-039 Backpressure: in_vec = 8'hC0, out_ready low for 3 cycles -> idx = 7 holds stable for 3 cycles; then idx 7, 6 stream with out_ready = 1.
REQ-040 Back-to-back: first vector 8'h01, second vector 8'h80 presented during the last beat -> beats idx 0 (last) then idx 7 (last) on adjacent cycles, no bubble.
REQ-041 Reset mid-drain: in_vec = 8'hFF, rst_n low after 2 beats -> out_valid = 0 and in_ready = 1 next cycle; a new vector 8'h08 then yields idx = 3 only.
